// File: rtl/pa_pkg.sv
// Shared definitions for the PA measurement blocks: UART command headers,
// packed IQ field layout and a small unsigned max helper.
package pa_pkg;

    localparam logic [31:0] CMD_PWR_AVG  = 32'h1f1a_5a5a;
    localparam logic [31:0] CMD_PWR_PEAK = 32'h1f1a_5b5b;
    localparam logic [31:0] CMD_PWR_STAT = 32'h1f1a_5c5c;
    localparam logic [31:0] CMD_PWR_CLR  = 32'h1f1a_5d5d;

    localparam int IQ_W     = 16;
    localparam int IQ_I_LSB = 0;
    localparam int IQ_Q_LSB = 16;

    function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pa_iq_power_meter_if.sv
// Sample stream, UART command/reply and measurement results of the power meter.
interface pa_iq_power_meter_if;

    logic        din_stat;
    logic [31:0] din_iq;
    logic        rv_uart_vld;
    logic [63:0] rv_uart_data;
    logic [31:0] pwr_avg;
    logic [31:0] pwr_peak;
    logic        pwr_upd;
    logic        ovl_flag;
    logic        uart_send_en;
    logic [63:0] sd_uart_data;

    modport master (
        output din_stat, din_iq, rv_uart_vld, rv_uart_data,
        input  pwr_avg, pwr_peak, pwr_upd, ovl_flag, uart_send_en, sd_uart_data
    );

    modport slave (
        input  din_stat, din_iq, rv_uart_vld, rv_uart_data,
        output pwr_avg, pwr_peak, pwr_upd, ovl_flag, uart_send_en, sd_uart_data
    );

endinterface

// File: rtl/pa_iq_power_meter_iq_mag2_pipe.sv
// Three-stage valid-tagged I^2+Q^2 pipeline; data stages load only with a valid sample.
module iq_mag2_pipe
    import pa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] iq,
    output logic        out_vld,
    output logic [31:0] mag2
);

    logic signed [IQ_W-1:0] i_s1, q_s1;
    logic                   v_s1;
    logic [30:0]            ii_s2, qq_s2;
    logic                   v_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_s1    <= '0;
            q_s1    <= '0;
            v_s1    <= 1'b0;
            ii_s2   <= '0;
            qq_s2   <= '0;
            v_s2    <= 1'b0;
            mag2    <= '0;
            out_vld <= 1'b0;
        end else begin
            v_s1    <= in_vld;
            v_s2    <= v_s1;
            out_vld <= v_s2;
            if (in_vld) begin
                i_s1 <= iq[IQ_I_LSB +: IQ_W];
                q_s1 <= iq[IQ_Q_LSB +: IQ_W];
            end
            // 31 bits hold the worst case (-32768)^2 = 2^30 exactly
            if (v_s1) begin
                ii_s2 <= 31'(i_s1) * 31'(i_s1);
                qq_s2 <= 31'(q_s1) * 31'(q_s1);
            end
            if (v_s2) begin
                mag2 <= {1'b0, ii_s2} + {1'b0, qq_s2};
            end
        end
    end

endmodule

// File: rtl/pa_iq_power_meter.sv
// Windowed mean/peak IQ power meter with sticky overload flag and UART query/clear.
module pa_iq_power_meter
    import pa_pkg::*;
#(
    parameter int          WIN_LOG2   = 10,
    parameter logic [31:0] OVL_THRESH = 32'h2000_0000
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    pa_iq_power_meter_if.slave   bus
);

    logic                  p_vld;
    logic [31:0]           p;
    logic [31+WIN_LOG2:0]  acc;
    logic [31+WIN_LOG2:0]  acc_sum;
    logic [WIN_LOG2-1:0]   cnt;
    logic [31:0]           run_peak;
    logic [31:0]           peak_next;
    logic                  win_end;
    logic                  fin_vld;
    logic [31:0]           fin_avg;
    logic [31:0]           fin_peak;
    logic                  is_clr;

    iq_mag2_pipe u_mag2 (
        .clk     (clk_50m),
        .rst     (rst),
        .in_vld  (bus.din_stat),
        .iq      (bus.din_iq),
        .out_vld (p_vld),
        .mag2    (p)
    );

    assign acc_sum   = acc + {{WIN_LOG2{1'b0}}, p};
    assign peak_next = max_u32(run_peak, p);
    assign win_end   = p_vld && (cnt == '1);
    assign is_clr    = bus.rv_uart_vld && (bus.rv_uart_data[63:32] == CMD_PWR_CLR);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            acc              <= '0;
            cnt              <= '0;
            run_peak         <= '0;
            fin_vld          <= 1'b0;
            fin_avg          <= '0;
            fin_peak         <= '0;
            bus.pwr_avg      <= '0;
            bus.pwr_peak     <= '0;
            bus.pwr_upd      <= 1'b0;
            bus.ovl_flag     <= 1'b0;
            bus.uart_send_en <= 1'b0;
            bus.sd_uart_data <= '0;
        end else begin
            bus.pwr_upd      <= 1'b0;
            bus.uart_send_en <= 1'b0;
            fin_vld          <= 1'b0;

            // Clear also cancels a window result still waiting to be published
            if (is_clr) begin
                acc          <= '0;
                cnt          <= '0;
                run_peak     <= '0;
                bus.ovl_flag <= 1'b0;
            end else begin
                if (p_vld) begin
                    if (win_end) begin
                        acc      <= '0;
                        cnt      <= '0;
                        run_peak <= '0;
                        fin_vld  <= 1'b1;
                        fin_avg  <= acc_sum[WIN_LOG2 +: 32];
                        fin_peak <= peak_next;
                    end else begin
                        acc      <= acc_sum;
                        cnt      <= cnt + WIN_LOG2'(1);
                        run_peak <= peak_next;
                    end
                end
                if (fin_vld) begin
                    bus.pwr_avg  <= fin_avg;
                    bus.pwr_peak <= fin_peak;
                    bus.pwr_upd  <= 1'b1;
                    if (fin_avg > OVL_THRESH) begin
                        bus.ovl_flag <= 1'b1;
                    end
                end
            end

            if (bus.rv_uart_vld) begin
                case (bus.rv_uart_data)
                    {CMD_PWR_AVG, 32'd0}: begin
                        bus.uart_send_en <= 1'b1;
                        bus.sd_uart_data <= {CMD_PWR_AVG, bus.pwr_avg};
                    end
                    {CMD_PWR_PEAK, 32'd0}: begin
                        bus.uart_send_en <= 1'b1;
                        bus.sd_uart_data <= {CMD_PWR_PEAK, bus.pwr_peak};
                    end
                    {CMD_PWR_STAT, 32'd0}: begin
                        bus.uart_send_en <= 1'b1;
                        bus.sd_uart_data <= {CMD_PWR_STAT, 31'd0, bus.ovl_flag};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pa_iq_power_meter.sv
// Directed bench for pa_iq_power_meter with a 16-sample window.
module tb_pa_iq_power_meter;

    logic clk_50m = 1'b0;
    logic rst;
    always #5 clk_50m = ~clk_50m;

    pa_iq_power_meter_if bus ();

    pa_iq_power_meter #(
        .WIN_LOG2   (4),
        .OVL_THRESH (32'h2000_0000)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_cyc = 0;
    int last_cyc = 0;
    int base = 0;
    logic [31:0] upd_avg [8];
    logic [31:0] upd_peak [8];

    always @(posedge clk_50m) cyc <= cyc + 1;

    always @(negedge clk_50m) begin
        if (bus.pwr_upd === 1'b1) begin
            if (upd_cnt < 8) begin
                upd_avg[upd_cnt]  = bus.pwr_avg;
                upd_peak[upd_cnt] = bus.pwr_peak;
            end
            upd_cnt = upd_cnt + 1;
            upd_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_50m);
            bus.din_stat = 1'b0;
        end
    endtask

    task automatic sample(input logic [15:0] i, input logic [15:0] q);
        @(negedge clk_50m);
        bus.din_stat = 1'b1;
        bus.din_iq   = {q, i};
        last_cyc     = cyc;
    endtask

    task automatic cmd(input logic [63:0] w);
        @(negedge clk_50m);
        bus.din_stat     = 1'b0;
        bus.rv_uart_vld  = 1'b1;
        bus.rv_uart_data = w;
        @(negedge clk_50m);
        bus.rv_uart_vld  = 1'b0;
        bus.rv_uart_data = '0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_avg"},  64'(bus.pwr_avg),      64'd0);
        chk({tag, "_peak"}, 64'(bus.pwr_peak),     64'd0);
        chk({tag, "_upd"},  64'(bus.pwr_upd),      64'd0);
        chk({tag, "_ovl"},  64'(bus.ovl_flag),     64'd0);
        chk({tag, "_send"}, 64'(bus.uart_send_en), 64'd0);
        chk({tag, "_sd"},   bus.sd_uart_data,      64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.din_stat     = 1'b0;
        bus.din_iq       = '0;
        bus.rv_uart_vld  = 1'b0;
        bus.rv_uart_data = '0;
        repeat (3) @(negedge clk_50m);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // constant 0x4000 on both rails: p = 2^29, avg == threshold, no overload
        for (int k = 0; k < 16; k++) sample(16'h4000, 16'h4000);
        idle(8);
        chk("t1_upd_cnt", 64'(upd_cnt), 64'd1);
        chk("t1_upd_lat", 64'(upd_cyc), 64'(last_cyc + 5));
        chk("t1_avg",  64'(bus.pwr_avg),  64'h2000_0000);
        chk("t1_peak", 64'(bus.pwr_peak), 64'h2000_0000);
        chk("t1_ovl",  64'(bus.ovl_flag), 64'd0);

        // one full-scale negative sample among zeros
        for (int k = 0; k < 15; k++) sample(16'h0000, 16'h0000);
        sample(16'h8000, 16'h8000);
        idle(8);
        chk("t2_upd_cnt", 64'(upd_cnt), 64'd2);
        chk("t2_avg",  64'(bus.pwr_avg),  64'h0800_0000);
        chk("t2_peak", 64'(bus.pwr_peak), 64'h8000_0000);
        cmd(64'h1f1a_5b5b_0000_0000);
        chk("q_peak_en", 64'(bus.uart_send_en), 64'd1);
        chk("q_peak_sd", bus.sd_uart_data, 64'h1f1a_5b5b_8000_0000);
        @(negedge clk_50m);
        chk("q_peak_en_drop", 64'(bus.uart_send_en), 64'd0);
        cmd(64'h1f1a_5a5a_0000_0000);
        chk("q_avg_en", 64'(bus.uart_send_en), 64'd1);
        chk("q_avg_sd", bus.sd_uart_data, 64'h1f1a_5a5a_0800_0000);

        cmd(64'h1f1a_5a5a_0000_0001);
        chk("unk_en", 64'(bus.uart_send_en), 64'd0);
        chk("unk_sd", bus.sd_uart_data, 64'h1f1a_5a5a_0800_0000);

        // gapped stream: one valid every third cycle
        for (int k = 0; k < 16; k++) begin
            sample(16'h4000, 16'h4000);
            idle(2);
        end
        idle(6);
        chk("t3_upd_cnt", 64'(upd_cnt), 64'd3);
        chk("t3_upd_lat", 64'(upd_cyc), 64'(last_cyc + 5));
        chk("t3_avg", 64'(bus.pwr_avg), 64'h2000_0000);

        // two back-to-back windows of ramps, I = k*256 then I = Q = k*256
        for (int k = 0; k < 16; k++) sample(16'(k << 8), 16'h0000);
        for (int k = 0; k < 16; k++) sample(16'(k << 8), 16'(k << 8));
        idle(8);
        chk("t3b_upd_cnt", 64'(upd_cnt), 64'd5);
        chk("t3b_upd_lat", 64'(upd_cyc), 64'(last_cyc + 5));
        chk("t3b_avg0",  64'(upd_avg[3]),  64'h004D_8000);
        chk("t3b_peak0", 64'(upd_peak[3]), 64'h00E1_0000);
        chk("t3b_avg1",  64'(upd_avg[4]),  64'h009B_0000);
        chk("t3b_peak1", 64'(upd_peak[4]), 64'h01C2_0000);

        // overload: 0x5A82^2 * 2 = 0x3FFF_5408 > threshold
        for (int k = 0; k < 16; k++) sample(16'h5A82, 16'h5A82);
        idle(8);
        chk("t4_avg", 64'(bus.pwr_avg), 64'h3FFF_5408);
        chk("t4_ovl", 64'(bus.ovl_flag), 64'd1);
        for (int k = 0; k < 16; k++) sample(16'h0000, 16'h0000);
        idle(8);
        chk("t4_avg_zero", 64'(bus.pwr_avg), 64'd0);
        chk("t4_ovl_sticky", 64'(bus.ovl_flag), 64'd1);
        cmd(64'h1f1a_5c5c_0000_0000);
        chk("q_stat1_sd", bus.sd_uart_data, 64'h1f1a_5c5c_0000_0001);

        // clear lands on the cycle the window result would be published
        base = upd_cnt;
        for (int k = 0; k < 16; k++) sample(16'h5A82, 16'h5A82);
        idle(3);
        cmd(64'h1f1a_5d5d_0000_0000);
        idle(6);
        chk("clr_no_upd", 64'(upd_cnt), 64'(base));
        chk("clr_ovl", 64'(bus.ovl_flag), 64'd0);
        chk("clr_avg_kept", 64'(bus.pwr_avg), 64'd0);
        cmd(64'h1f1a_5c5c_0000_0000);
        chk("q_stat0_en", 64'(bus.uart_send_en), 64'd1);
        chk("q_stat0_sd", bus.sd_uart_data, 64'h1f1a_5c5c_0000_0000);

        // reset mid-window discards the partial window
        for (int k = 0; k < 16; k++) sample(16'h5A82, 16'h5A82);
        idle(8);
        chk("t5_pre_ovl", 64'(bus.ovl_flag), 64'd1);
        for (int k = 0; k < 7; k++) sample(16'h8000, 16'h8000);
        @(negedge clk_50m);
        rst          = 1'b1;
        bus.din_stat = 1'b0;
        @(negedge clk_50m);
        chk_outputs_zero("midrst");
        rst  = 1'b0;
        base = upd_cnt;
        for (int k = 0; k < 15; k++) sample(16'h4000, 16'h4000);
        idle(8);
        chk("t5_no_early_upd", 64'(upd_cnt), 64'(base));
        sample(16'h4000, 16'h4000);
        idle(8);
        chk("t5_upd_cnt", 64'(upd_cnt), 64'(base + 1));
        chk("t5_upd_lat", 64'(upd_cyc), 64'(last_cyc + 5));
        chk("t5_avg", 64'(bus.pwr_avg), 64'h2000_0000);
        chk("t5_ovl", 64'(bus.ovl_flag), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
